// File: rtl/processinho_pkg.sv
// ============================================================================
// processinho_pkg : shared types and constants for the RAM access controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package processinho_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    localparam int c_addr_w = 4;
    localparam int c_data_w = 8;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : two-requester grant logic, fixed-priority or round-robin
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb2
    import processinho_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic i_req_cpu,
    input  logic i_req_ldr,
    input  logic i_owner,
    output logic o_valid,
    output logic o_grant
);

    always_comb begin
        o_valid = i_req_cpu | i_req_ldr;
        o_grant = i_req_ldr ? REQ_LDR : REQ_CPU;
        // On a tie in round-robin mode the requester that did not go last wins
        if (RR_EN && i_req_cpu && i_req_ldr) begin
            o_grant = ~i_owner;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_ctrl.sv
// ============================================================================
// ram_ctrl : shares the single-port data RAM between CPU and loader.
// Define RAM_CTRL_RR_EN for round-robin arbitration (default: loader priority).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_ctrl
    import processinho_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner
);

`ifdef RAM_CTRL_RR_EN
    localparam bit c_rr_en = 1'b1;
`else
    localparam bit c_rr_en = 1'b0;
`endif

    state_t            r_state;
    state_t            w_next_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_owner;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ldr_rdata;
    logic              w_valid;
    logic              w_grant;

    rr_arb2 #(
        .RR_EN (c_rr_en)
    ) u_arb (
        .i_req_cpu (cpu_req),
        .i_req_ldr (ldr_req),
        .i_owner   (r_owner),
        .o_valid   (w_valid),
        .o_grant   (w_grant)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_owner     <= REQ_LDR;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            // Request fields are frozen at grant so the requester may change them afterwards
            if (r_state == IDLE && w_valid) begin
                r_owner <= w_grant;
                r_we    <= (w_grant == REQ_LDR) ? ldr_we    : cpu_we;
                r_addr  <= (w_grant == REQ_LDR) ? ldr_addr  : cpu_addr;
                r_wdata <= (w_grant == REQ_LDR) ? ldr_wdata : cpu_wdata;
            end
            if (r_state == RD_WAIT) begin
                if (r_owner == REQ_LDR) begin
                    r_ldr_rdata <= ram_rdata;
                end else begin
                    r_cpu_rdata <= ram_rdata;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        cpu_ack      = 1'b0;
        ldr_ack      = 1'b0;
        case (r_state)
            IDLE:    if (w_valid) w_next_state = ACCESS;
            ACCESS: begin
                // Gating with reset suppresses a write caught mid-transaction
                ram_en       = ~reset;
                ram_we       = ~reset & r_we;
                w_next_state = r_we ? DONE : RD_WAIT;
            end
            RD_WAIT: w_next_state = DONE;
            DONE: begin
                cpu_ack      = ~reset & (r_owner == REQ_CPU);
                ldr_ack      = ~reset & (r_owner == REQ_LDR);
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign cpu_rdata = r_cpu_rdata;
    assign ldr_rdata = r_ldr_rdata;
    assign busy      = (r_state != IDLE);
    assign owner     = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_ram_ctrl.sv
// ============================================================================
// tb_ram_ctrl : directed self-checking bench for ram_ctrl with a RAM model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [3:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       ldr_req = 1'b0, ldr_we = 1'b0;
    logic [3:0] ldr_addr = '0;
    logic [7:0] ldr_wdata = '0;
    logic       ldr_ack;
    logic [7:0] ldr_rdata;
    logic       ram_en, ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic       busy, owner;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [16];

    always #5 clock = ~clock;

    ram_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
    );

    // Single-port RAM with one-cycle registered read
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    // Runs one access for one requester; reports latency and what the RAM saw in cycle 1
    task automatic do_access(input logic who, input logic we, input logic [3:0] addr,
                             input logic [7:0] wdata, input logic [3:0] late_addr,
                             output int lat, output logic [7:0] rd,
                             output logic s_en, output logic s_we, output logic [3:0] s_addr,
                             output logic [7:0] s_wdata, output logic bad_ack);
        @(negedge clock);
        if (who) begin ldr_req = 1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; end
        else     begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
        lat = -1; rd = '0; bad_ack = 0; s_en = 0; s_we = 0; s_addr = '0; s_wdata = '0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clock);
            if (k == 1) begin
                s_en = ram_en; s_we = ram_we; s_addr = ram_addr; s_wdata = ram_wdata;
                if (who) ldr_addr = late_addr; else cpu_addr = late_addr;
            end
            if (who ? cpu_ack : ldr_ack) bad_ack = 1;
            if (who ? ldr_ack : cpu_ack) begin lat = k; rd = who ? ldr_rdata : cpu_rdata; end
        end
        if (who) ldr_req = 0; else cpu_req = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        @(negedge clock); @(negedge clock);
        n_cmp++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL reset_cpu_ack: got %b want 0", cpu_ack); end
        n_cmp++; if (ldr_ack !== 1'b0) begin n_err++; $display("FAIL reset_ldr_ack: got %b want 0", ldr_ack); end
        n_cmp++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_ctl: got en=%b we=%b want 0 0", ram_en, ram_we); end
        n_cmp++; if (ram_addr !== 4'h0 || ram_wdata !== 8'h00) begin n_err++; $display("FAIL reset_ram_bus: got %h %h want 0 00", ram_addr, ram_wdata); end
        n_cmp++; if (cpu_rdata !== 8'h00 || ldr_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h %h want 00 00", cpu_rdata, ldr_rdata); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (owner !== 1'b1) begin n_err++; $display("FAIL reset_owner: got %b want 1", owner); end
        reset = 0;
        @(negedge clock);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_cpu_write_read();
        int lat; logic [7:0] rd, d; logic e, w, b; logic [3:0] a;
        do_access(1'b0, 1'b1, 4'h3, 8'hA5, 4'h3, lat, rd, e, w, a, d, b);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL cpu_wr_latency: got %0d want 2", lat); end
        n_cmp++; if (e !== 1'b1 || w !== 1'b1) begin n_err++; $display("FAIL cpu_wr_ctl: got en=%b we=%b want 1 1", e, w); end
        n_cmp++; if (a !== 4'h3 || d !== 8'hA5) begin n_err++; $display("FAIL cpu_wr_bus: got %h %h want 3 a5", a, d); end
        n_cmp++; if (b !== 1'b0) begin n_err++; $display("FAIL cpu_wr_other_ack: got %b want 0", b); end
        do_access(1'b0, 1'b0, 4'h3, 8'h00, 4'h3, lat, rd, e, w, a, d, b);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL cpu_rd_latency: got %0d want 3", lat); end
        n_cmp++; if (rd !== 8'hA5) begin n_err++; $display("FAIL cpu_rd_data: got %h want a5", rd); end
        n_cmp++; if (e !== 1'b1 || w !== 1'b0) begin n_err++; $display("FAIL cpu_rd_ctl: got en=%b we=%b want 1 0", e, w); end
        n_cmp++; if (owner !== 1'b0) begin n_err++; $display("FAIL cpu_owner: got %b want 0", owner); end
    endtask

    task automatic test_loader_fill();
        int lat; logic [7:0] rd, d; logic e, w, b; logic [3:0] a;
        for (int i = 0; i < 16; i++) begin
            do_access(1'b1, 1'b1, 4'(i), 8'(i) ^ 8'hFF, 4'(i), lat, rd, e, w, a, d, b);
            n_cmp++; if (lat !== 2 || a !== 4'(i)) begin n_err++; $display("FAIL ldr_wr[%0d]: got lat=%0d addr=%h want 2 %h", i, lat, a, 4'(i)); end
        end
        for (int i = 0; i < 16; i++) begin
            do_access(1'b0, 1'b0, 4'(i), 8'h00, 4'(i), lat, rd, e, w, a, d, b);
            n_cmp++; if (rd !== (8'(i) ^ 8'hFF) || lat !== 3) begin n_err++; $display("FAIL cpu_rd_fill[%0d]: got %h lat=%0d want %h 3", i, rd, lat, 8'(i) ^ 8'hFF); end
            n_cmp++; if (ldr_rdata !== 8'h00 || b !== 1'b0) begin n_err++; $display("FAIL ldr_untouched[%0d]: got %h ack=%b want 00 0", i, ldr_rdata, b); end
        end
    endtask

    task automatic test_addr_latch();
        int lat; logic [7:0] rd, d; logic e, w, b; logic [3:0] a;
        do_access(1'b0, 1'b1, 4'h5, 8'h66, 4'h9, lat, rd, e, w, a, d, b);
        n_cmp++; if (a !== 4'h5) begin n_err++; $display("FAIL latch_addr: got %h want 5", a); end
        n_cmp++; if (ram_addr !== 4'h5) begin n_err++; $display("FAIL latch_addr_hold: got %h want 5", ram_addr); end
        do_access(1'b0, 1'b0, 4'h9, 8'h00, 4'h9, lat, rd, e, w, a, d, b);
        n_cmp++; if (rd !== 8'hF6) begin n_err++; $display("FAIL latch_addr9: got %h want f6", rd); end
        do_access(1'b0, 1'b0, 4'h5, 8'h00, 4'h5, lat, rd, e, w, a, d, b);
        n_cmp++; if (rd !== 8'h66) begin n_err++; $display("FAIL latch_addr5: got %h want 66", rd); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [7:0] rd, d; logic e, w, b; logic [3:0] a; logic seen;
        do_access(1'b0, 1'b1, 4'h7, 8'h11, 4'h7, lat, rd, e, w, a, d, b);
        @(negedge clock);
        cpu_req = 1; cpu_we = 1; cpu_addr = 4'h7; cpu_wdata = 8'h99;
        @(negedge clock);
        n_cmp++; if (ram_en !== 1'b1) begin n_err++; $display("FAIL mid_access: got en=%b want 1", ram_en); end
        reset = 1;
        #1;
        n_cmp++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin n_err++; $display("FAIL mid_suppress: got en=%b we=%b want 0 0", ram_en, ram_we); end
        cpu_req = 0;
        @(negedge clock);
        n_cmp++; if (cpu_ack !== 1'b0 || busy !== 1'b0 || owner !== 1'b1) begin n_err++; $display("FAIL mid_state: got ack=%b busy=%b owner=%b want 0 0 1", cpu_ack, busy, owner); end
        n_cmp++; if (ram_addr !== 4'h0 || ram_wdata !== 8'h00 || cpu_rdata !== 8'h00) begin n_err++; $display("FAIL mid_regs: got %h %h %h want 0 00 00", ram_addr, ram_wdata, cpu_rdata); end
        reset = 0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (cpu_ack || ldr_ack || busy) seen = 1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_no_ack: got activity=%b want 0", seen); end
        do_access(1'b0, 1'b0, 4'h7, 8'h00, 4'h7, lat, rd, e, w, a, d, b);
        n_cmp++; if (rd !== 8'h11) begin n_err++; $display("FAIL mid_readback: got %h want 11", rd); end
    endtask

    task automatic test_back_to_back();
        logic exp_busy [7] = '{1, 1, 1, 0, 1, 1, 1};
        logic exp_ack  [7] = '{0, 0, 1, 0, 0, 0, 1};
        @(negedge clock);
        cpu_req = 1; cpu_we = 0; cpu_addr = 4'h3;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            n_cmp++; if (busy !== exp_busy[k]) begin n_err++; $display("FAIL b2b_busy[%0d]: got %b want %b", k + 1, busy, exp_busy[k]); end
            n_cmp++; if (cpu_ack !== exp_ack[k]) begin n_err++; $display("FAIL b2b_ack[%0d]: got %b want %b", k + 1, cpu_ack, exp_ack[k]); end
        end
        cpu_req = 0;
        n_cmp++; if (cpu_rdata !== 8'hFC) begin n_err++; $display("FAIL b2b_data: got %h want fc", cpu_rdata); end
    endtask

    task automatic test_arbitration();
        logic got [5];
        logic exp [5];
        int   ng;
        logic done, bad;
`ifdef RAM_CTRL_RR_EN
        exp = '{0, 1, 0, 1, 0};
`else
        exp = '{1, 1, 1, 1, 0};
`endif
        got = '{1'bx, 1'bx, 1'bx, 1'bx, 1'bx};
        reset = 1;
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        cpu_req = 1; cpu_we = 1; cpu_addr = 4'hC; cpu_wdata = 8'hC0;
        ldr_req = 1; ldr_we = 1; ldr_addr = 4'hD; ldr_wdata = 8'hD0;
        ng = 0; done = 0; bad = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clock);
            if (ram_en && ng < 5) begin got[ng] = owner; ng++; end
            if ((cpu_ack && owner !== 1'b0) || (ldr_ack && owner !== 1'b1) || (cpu_ack && ldr_ack)) bad = 1;
            if (ldr_ack && ng >= 4) ldr_req = 0;
            if (cpu_ack && ng >= 5) begin cpu_req = 0; done = 1; end
        end
        cpu_req = 0; ldr_req = 0;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL arb_timeout: got %0d grants want 5", ng); end
        n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL arb_ack_owner: got bad=%b want 0", bad); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (got[i] !== exp[i]) begin n_err++; $display("FAIL arb_grant[%0d]: got %b want %b", i, got[i], exp[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        test_reset();
        test_cpu_write_read();
        test_loader_fill();
        test_addr_latch();
        test_reset_mid();
        test_back_to_back();
        test_arbitration();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_ctrl.md
# ram_ctrl

Sequences every access to the single-port data RAM of the processor and shares that RAM between two requesters: the datapath (CPU load/store through MAR/data bus) and the program/data loader port. The block arbitrates, drives the RAM control pins for exactly one access per grant, captures read data, and returns a one-cycle acknowledge to the owner. It sits between `datapath`/control signals and the `ram` instance. The RAM itself has a one-cycle registered read.

## Interface
Parameters:
- ADDR_W, 4, RAM address width
- DATA_W, 8, RAM data width

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock, sampled on the rising edge
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address (MAR value)
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid in the cpu_ack cycle, held until next CPU read completes
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata  same as cpu_* for the loader
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en with ram_we=0
- busy  out  1  high in any state but IDLE
- owner  out  1  current/last grant: 0 = CPU, 1 = loader

## Operation
- FSM states: IDLE, ACCESS, RD_WAIT, DONE.
- IDLE: if any req high, arbitrate, latch winner's we/addr/wdata into internal registers, set owner, go ACCESS. No req: stay.
- ACCESS: ram_en=1, ram_we=latched we, ram_addr/ram_wdata from latched registers (one cycle only). Write → DONE; read → RD_WAIT.
- RD_WAIT: capture ram_rdata into owner's rdata register → DONE.
- DONE: owner's ack=1 for this cycle only → IDLE.
- Request fields are latched at grant; changes after grant do not affect the access.
- Requester must drop req in the cycle after ack; req still high in IDLE is a new transaction.
- Losing requester simply waits; its req is never dropped by the controller.
- ram_addr/ram_wdata hold last latched values outside ACCESS; ram_en=ram_we=0 outside ACCESS.
- Non-owner ack always 0; non-owner rdata unchanged.
- Reset values: state IDLE, all acks 0, ram_en 0, ram_we 0, ram_addr 0, ram_wdata 0, cpu_rdata 0, ldr_rdata 0, busy 0, owner 1 (loader last).
- Reset mid-operation: transaction abandoned, no ack pulse, any pending RAM write in that cycle suppressed (ram_en forced 0 while reset high).

## Timing
- Req seen in IDLE at cycle 0; ACCESS cycle 1; write ack in cycle 2; read ack with data in cycle 3.
- Back-to-back: next grant earliest at cycle 3 (write) / 4 (read) after previous cycle 0.
- Throughput: one access per 3 (write) or 4 (read) cycles.
- Both reqs in same IDLE cycle: resolved per Configuration.

## Configuration
- RAM_CTRL_RR_EN defined: two-way round-robin; on simultaneous requests the requester that is not `owner` wins. Single request always wins.
- Undefined: fixed priority, loader always beats CPU; owner still updates but does not affect arbitration.

## Structure
- Shared package processinho_pkg: FSM state enum (IDLE, ACCESS, RD_WAIT, DONE), requester IDs (REQ_CPU=0, REQ_LDR=1), default ADDR_W/DATA_W constants.
- One sub-module: rr_arb2 (2-input grant logic, takes owner pointer and macro-selected mode); FSM and datapath registers in ram_ctrl.

## Test plan
- CPU write addr 0x3 data 0xA5 → ram_en=ram_we=1, ram_addr=0x3 in cycle 1, cpu_ack in cycle 2; CPU read 0x3 → cpu_ack cycle 3, cpu_rdata=0xA5.
- Loader writes 0x00..0x0F with data=addr^0xFF, then CPU reads all 16 → each cpu_rdata matches, ldr_rdata untouched.
- Both req in same cycle, repeated 4 times with req held: RR_EN → owners L? no, CPU,LDR,CPU,LDR starting CPU after reset; without macro → all loader grants until ldr_req drops.
- Change cpu_addr 0x5→0x9 one cycle after grant → RAM sees 0x5 only.
- Assert reset during ACCESS of a write to 0x7 (old value 0x11) → no ack, ram_en 0, subsequent read of 0x7 returns 0x11; all outputs at reset values.
- Req held high after ack → second identical access starts next IDLE cycle; busy low exactly one cycle between.
